// File: rtl/counter_sweep_ctrl_if.sv
// Sweep controller bundle: request/config inputs, counter feedback and command outputs, status.
// The optional hold input exists only when SWEEP_HOLD_EN is defined.
interface counter_sweep_ctrl_if;
   logic       start;
   logic       stop;
   logic [3:0] lo;
   logic [3:0] hi;
   logic [3:0] cycles;
   logic [3:0] ctr_q;
   logic       ctr_load;
   logic [3:0] ctr_data;
   logic       ctr_enable;
   logic       ctr_select;
   logic       busy;
   logic       done;
   logic       err;
   logic [3:0] pass_cnt;
`ifdef SWEEP_HOLD_EN
   logic       hold;

   modport master (
      output start, stop, lo, hi, cycles, ctr_q, hold,
      input  ctr_load, ctr_data, ctr_enable, ctr_select, busy, done, err, pass_cnt
   );
   modport slave (
      input  start, stop, lo, hi, cycles, ctr_q, hold,
      output ctr_load, ctr_data, ctr_enable, ctr_select, busy, done, err, pass_cnt
   );
`else
   modport master (
      output start, stop, lo, hi, cycles, ctr_q,
      input  ctr_load, ctr_data, ctr_enable, ctr_select, busy, done, err, pass_cnt
   );
   modport slave (
      input  start, stop, lo, hi, cycles, ctr_q,
      output ctr_load, ctr_data, ctr_enable, ctr_select, busy, done, err, pass_cnt
   );
`endif
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Drives an external up/down counter lo->hi->lo for N passes (N=0: until stop); commands are
// combinational from state and ctr_q, err is a registered pulse. Macro SWEEP_HOLD_EN adds a hold input.
module counter_sweep_ctrl (
   input  logic                  clk,
   input  logic                  rst_n,
   counter_sweep_ctrl_if.slave   sif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_UP,
      S_DOWN,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] lo_q, lo_d;
   logic [3:0] hi_q, hi_d;
   logic [3:0] cyc_q, cyc_d;
   logic [3:0] pass_q, pass_d;
   logic       err_q, err_d;

   logic       hold_w;
   logic       load_w;
   logic [3:0] data_w;
   logic       enable_w;
   logic       select_w;

`ifdef SWEEP_HOLD_EN
   assign hold_w = sif.hold;
`else
   assign hold_w = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lo_q    <= 4'd0;
         hi_q    <= 4'd0;
         cyc_q   <= 4'd0;
         pass_q  <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         cyc_q   <= cyc_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      cyc_d    = cyc_q;
      pass_d   = pass_q;
      err_d    = 1'b0;
      load_w   = 1'b0;
      data_w   = 4'd0;
      enable_w = 1'b0;
      select_w = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sif.start) begin
               if (sif.lo < sif.hi) begin
                  lo_d    = sif.lo;
                  hi_d    = sif.hi;
                  cyc_d   = sif.cycles;
                  pass_d  = 4'd0;
                  state_d = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (sif.stop) begin
               state_d = S_IDLE;
            end else begin
               load_w  = 1'b1;
               data_w  = lo_q;
               state_d = S_UP;
            end
         end
         S_UP: begin
            // Reaching the ceiling costs one idle dwell cycle before turning around.
            if (sif.stop) begin
               state_d = S_IDLE;
            end else if (!hold_w) begin
               if (sif.ctr_q != hi_q) begin
                  enable_w = 1'b1;
                  select_w = 1'b1;
               end else begin
                  state_d = S_DOWN;
               end
            end
         end
         S_DOWN: begin
            if (sif.stop) begin
               state_d = S_IDLE;
            end else if (!hold_w) begin
               if (sif.ctr_q != lo_q) begin
                  enable_w = 1'b1;
               end else begin
                  pass_d = pass_q + 4'd1;
                  if ((cyc_q != 4'd0) && ((pass_q + 4'd1) == cyc_q))
                     state_d = S_DONE;
                  else
                     state_d = S_UP;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign sif.ctr_load   = load_w;
   assign sif.ctr_data   = data_w;
   assign sif.ctr_enable = enable_w;
   assign sif.ctr_select = select_w;
   assign sif.busy       = (state_q != S_IDLE);
   assign sif.done       = (state_q == S_DONE);
   assign sif.err        = err_q;
   assign sif.pass_cnt   = pass_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural external counter and a queue scoreboard.
module tb_counter_sweep_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   counter_sweep_ctrl_if sif();

   counter_sweep_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif)
   );

   // external 4-bit loadable up/down counter
   logic [3:0] ctr_r = 4'd0;
   always @(posedge clk) begin
      if (sif.ctr_load)
         ctr_r <= sif.ctr_data;
      else if (sif.ctr_enable)
         ctr_r <= sif.ctr_select ? ctr_r + 4'd1 : ctr_r - 4'd1;
   end
   assign sif.ctr_q = ctr_r;

   int checks = 0;
   int passes = 0;
   logic [3:0] exp_q[$];
   int         done_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Runs one full sweep; optional hold of hl cycles starting in cycle hk after the accept edge.
   task automatic run_sweep(input logic [3:0] l, input logic [3:0] h, input logic [3:0] c,
                            input int hk, input int hl);
      int n;
      int exp_k;
      int done_k;
      int dones;
      logic [3:0] dup;
      n = int'(h) - int'(l) + 1;
      exp_q.delete();
      for (int p = 0; p < int'(c); p++) begin
         for (int v = int'(l); v <= int'(h); v++) exp_q.push_back(4'(v));
         for (int v = int'(h); v >= int'(l); v--) exp_q.push_back(4'(v));
      end
      if (hl > 0) begin
         dup = exp_q[hk-1];
         for (int i = 0; i < hl; i++) exp_q.insert(hk-1, dup);
      end
      done_q.push_back(1 + 2*n*int'(c) + hl);
      sif.lo = l; sif.hi = h; sif.cycles = c; sif.start = 1'b1;
      step();
      sif.start = 1'b0;
      check("load_cmd", sif.ctr_load, 1);
      check("load_data", sif.ctr_data, l);
      check("load_busy", sif.busy, 1);
      check("load_no_en", sif.ctr_enable, 0);
      exp_k  = done_q.pop_front();
      done_k = -1;
      dones  = 0;
      for (int k = 1; k <= exp_k + 4; k++) begin
         step();
`ifdef SWEEP_HOLD_EN
         if (hl > 0 && k == hk) begin sif.hold = 1'b1; #1; end
         if (hl > 0 && k == hk + hl) begin sif.hold = 1'b0; #1; end
         if (sif.hold) check("hold_en", sif.ctr_enable, 0);
`endif
         check("load_en_excl", sif.ctr_load & sif.ctr_enable, 0);
         if (!sif.ctr_enable) check("sel_idle", sif.ctr_select, 0);
         if (sif.done) begin
            dones++;
            if (done_k < 0) begin
               done_k = k;
               check("pass_at_done", sif.pass_cnt, c);
            end
         end else if (exp_q.size() > 0) begin
            check("ctr_seq", sif.ctr_q, exp_q.pop_front());
         end
      end
      check("done_cycle", done_k, exp_k);
      check("done_once", dones, 1);
      check("pass_hold", sif.pass_cnt, c);
      check("idle_after", sif.busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat[6];
      sif.start = 1'b0; sif.stop = 1'b0;
      sif.lo = 4'd0; sif.hi = 4'd0; sif.cycles = 4'd0;
`ifdef SWEEP_HOLD_EN
      sif.hold = 1'b0;
`endif
      // reset state
      #12;
      check("rst_busy", sif.busy, 0);
      check("rst_done", sif.done, 0);
      check("rst_err", sif.err, 0);
      check("rst_pass", sif.pass_cnt, 0);
      check("rst_load", sif.ctr_load, 0);
      check("rst_en", sif.ctr_enable, 0);
      check("rst_data", sif.ctr_data, 0);
      check("rst_sel", sif.ctr_select, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // basic single pass
      run_sweep(4'd2, 4'd5, 4'd1, 0, 0);

      // rejected start: lo == hi
      sif.lo = 4'd7; sif.hi = 4'd7; sif.cycles = 4'd1; sif.start = 1'b1;
      check("rej_err_pre", sif.err, 0);
      step();
      sif.start = 1'b0;
      check("rej_err", sif.err, 1);
      check("rej_busy", sif.busy, 0);
      check("rej_load", sif.ctr_load, 0);
      check("rej_en", sif.ctr_enable, 0);
      step();
      check("rej_err_clr", sif.err, 0);
      check("rej_busy2", sif.busy, 0);

      // continuous sweep, busy-start ignored, stop in DOWN
      pat = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1};
      exp_q.delete();
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 6; i++) exp_q.push_back(pat[i]);
      sif.lo = 4'd1; sif.hi = 4'd3; sif.cycles = 4'd0; sif.start = 1'b1;
      step();
      sif.start = 1'b0;
      for (int k = 1; k <= 23; k++) begin
         step();
         if (k == 10) begin
            sif.lo = 4'd7; sif.hi = 4'd7; sif.start = 1'b1;
         end
         if (k == 11) begin
            sif.start = 1'b0;
            check("busy_start_err", sif.err, 0);
            check("busy_start_busy", sif.busy, 1);
         end
         check("cont_no_done", sif.done, 0);
         check("cont_seq", sif.ctr_q, exp_q.pop_front());
      end
      check("cont_down_en", sif.ctr_enable, 1);
      check("cont_down_sel", sif.ctr_select, 0);
      check("cont_pass", sif.pass_cnt, 3);
      sif.stop = 1'b1;
      #1;
      check("stop_en", sif.ctr_enable, 0);
      check("stop_sel", sif.ctr_select, 0);
      step();
      sif.stop = 1'b0;
      check("stop_busy", sif.busy, 0);
      check("stop_done", sif.done, 0);
      check("stop_en2", sif.ctr_enable, 0);
      check("stop_pass", sif.pass_cnt, 3);
      for (int k = 0; k < 4; k++) begin
         step();
         check("stop_quiet", sif.done | sif.busy, 0);
      end

      // reset mid UP
      sif.lo = 4'd2; sif.hi = 4'd9; sif.cycles = 4'd1; sif.start = 1'b1;
      step();
      sif.start = 1'b0;
      for (int k = 1; k <= 3; k++) step();
      check("pre_rst_q", sif.ctr_q, 4);
      check("pre_rst_en", sif.ctr_enable, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", sif.busy, 0);
      check("mid_rst_en", sif.ctr_enable, 0);
      check("mid_rst_sel", sif.ctr_select, 0);
      check("mid_rst_load", sif.ctr_load, 0);
      check("mid_rst_pass", sif.pass_cnt, 0);
      check("mid_rst_done", sif.done | sif.err, 0);
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         check("post_rst_idle", {sif.busy, sif.done, sif.err, sif.ctr_enable, sif.ctr_load}, 0);
      end

      // two full-range passes
      run_sweep(4'd0, 4'd15, 4'd2, 0, 0);

`ifdef SWEEP_HOLD_EN
      run_sweep(4'd2, 4'd5, 4'd1, 2, 3);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
